bsg_mux2_merge_ctrl: RTL

Two-requester arbiter and merge controller for a per-bit 2:1 select datapath. It accepts words from two valid/ready producers and registers them, together with a per-bit select vector, into a one-entry output buffer. The consumer side sees a combinational per-bit mux of the two registered operands. The block either passes one producer's word whole (round-robin under contention) or, in merge mode, overlays requester 1's masked bits onto requester 0's word in a single transfer.

---
 rtl/bsg_mux2_merge_ctrl.sv | 116 +++++++++++
 1 files changed

// File: rtl/bsg_mux2_merge_ctrl.sv
// Two-requester arbiter and merge controller feeding a
// one-entry buffer whose output is a per-bit 2:1 mux.
module bsg_mux2_merge_ctrl #(
  parameter int width_p       = 64,
  parameter int count_width_p = 16
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     v0_i,
  input  logic [width_p-1:0]       data0_i,
  output logic                     ready0_o,
  input  logic                     v1_i,
  input  logic [width_p-1:0]       data1_i,
  input  logic [width_p-1:0]       mask1_i,
  output logic                     ready1_o,
  input  logic                     merge_en_i,
  output logic                     v_o,
  output logic [width_p-1:0]       data_o,
  output logic [width_p-1:0]       sel_o,
  input  logic                     yumi_i,
  output logic [count_width_p-1:0] merge_count_o
);

  logic                     full_q, full_d;
  logic [width_p-1:0]       reg0_q, reg0_d;
  logic [width_p-1:0]       reg1_q, reg1_d;
  logic [width_p-1:0]       sel_q, sel_d;
  logic                     last_q, last_d;
  logic [count_width_p-1:0] cnt_q, cnt_d;

  logic g0, g1, merge;
  logic can_accept, acc0, acc1, accept;

  // Grant decode: merge, round-robin, or single requester.
  always_comb begin
    g0    = 1'b0;
    g1    = 1'b0;
    merge = 1'b0;
    unique case (1'b1)
      (v0_i & v1_i & merge_en_i): begin
        g0    = 1'b1;
        g1    = 1'b1;
        merge = 1'b1;
      end
      (v0_i & v1_i & ~merge_en_i): begin
        g0 = last_q;
        g1 = ~last_q;
      end
      (v0_i & ~v1_i): g0 = 1'b1;
      (~v0_i & v1_i): g1 = 1'b1;
      default: ;
    endcase
  end

  // Handshakes; readys are held low while in reset.
  always_comb begin
    can_accept = ~full_q | yumi_i;
    acc0       = reset_n_i & can_accept & g0;
    acc1       = reset_n_i & can_accept & g1;
    accept     = acc0 | acc1;
  end

  // Next-state for buffer, operands, select, grant history, counter.
  always_comb begin
    full_d = full_q;
    reg0_d = reg0_q;
    reg1_d = reg1_q;
    sel_d  = sel_q;
    last_d = last_q;
    cnt_d  = cnt_q;
    if (accept)      full_d = 1'b1;
    else if (yumi_i) full_d = 1'b0;
    if (acc0) reg0_d = data0_i;
    if (acc1) reg1_d = data1_i;
    if (acc0 & acc1) begin
      sel_d = mask1_i;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end else if (acc0) begin
      sel_d  = '0;
      last_d = 1'b0;
    end else if (acc1) begin
      sel_d  = '1;
      last_d = 1'b1;
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      full_q <= 1'b0;
      reg0_q <= '0;
      reg1_q <= '0;
      sel_q  <= '0;
      last_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      full_q <= full_d;
      reg0_q <= reg0_d;
      reg1_q <= reg1_d;
      sel_q  <= sel_d;
      last_q <= last_d;
      cnt_q  <= cnt_d;
    end
  end

  // Outputs: per-bit mux of the registered operands.
  always_comb begin
    ready0_o      = acc0;
    ready1_o      = acc1;
    v_o           = full_q;
    sel_o         = sel_q;
    data_o        = (sel_q & reg1_q) | (~sel_q & reg0_q);
    merge_count_o = cnt_q;
  end

endmodule
